// File: rtl/pwm_capture_pkg.sv
// ============================================================================
// Module  : pwm_capture_pkg
// Brief   : Shared defaults and FSM state encoding for the PWM capture block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_capture_pkg;

    localparam int PERIOD      = 16;
    localparam int DUTY_W      = 4;
    localparam int CNT_W       = 8;
    localparam int LOW_TIMEOUT = 64;
    localparam int DUTY_MAX    = (1 << DUTY_W) - 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HIGH     = 3'd1,
        LOW      = 3'd2,
        STUCK_HI = 3'd3,
        STUCK_LO = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_capture_sync.sv
// ============================================================================
// Module  : pwm_capture_sync
// Brief   : 2-flop synchroniser with edge detect; PWM_CAPTURE_GLITCH_FILTER_EN
//           adds a 2-cycle stability filter in front of the edge detector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture_sync (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic w_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= pwm_in;
            r_sync <= r_meta;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic r_sync_d;
    logic r_filt;

    // Level is accepted only once two consecutive synchronised samples agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_d <= 1'b0;
            r_filt   <= 1'b0;
        end else begin
            r_sync_d <= r_sync;
            if (r_sync == r_sync_d) begin
                r_filt <= r_sync;
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign s    = w_level;
    assign rise = w_level & ~r_prev;
    assign fall = ~w_level & r_prev;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// Module  : pwm_capture
// Brief   : Measures an incoming 16-step PWM waveform and recovers its duty
//           code, period and stuck status. Optional macro:
//           PWM_CAPTURE_GLITCH_FILTER_EN (input stability filter).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
    parameter int PERIOD      = pwm_capture_pkg::PERIOD,
    parameter int DUTY_W      = pwm_capture_pkg::DUTY_W,
    parameter int CNT_W       = pwm_capture_pkg::CNT_W,
    parameter int LOW_TIMEOUT = pwm_capture_pkg::LOW_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic [CNT_W-1:0]  period_out,
    output logic              valid,
    output logic              period_err,
    output logic              stuck_high,
    output logic              stuck_low
);

    import pwm_capture_pkg::*;

    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  c_PERIOD   = CNT_W'(PERIOD);
    localparam logic [CNT_W:0]    c_PERIOD_X = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W-1:0]  c_TIMEOUT  = CNT_W'(LOW_TIMEOUT);
    localparam logic [DUTY_W-1:0] c_DUTY_MAX = '1;

    logic w_s;
    logic w_rise;
    logic w_fall;

    state_e r_state;
    state_e w_state_nxt;

    logic [CNT_W-1:0]  r_hi_cnt, w_hi_nxt, w_hi_inc;
    logic [CNT_W-1:0]  r_lo_cnt, w_lo_nxt, w_lo_inc;
    logic [DUTY_W-1:0] r_duty, w_duty_nxt;
    logic [CNT_W-1:0]  r_period, w_period_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_err, w_err_nxt;
    logic              r_stuck_hi, w_stuck_hi_nxt;
    logic              r_stuck_lo, w_stuck_lo_nxt;

    logic [CNT_W:0]    w_sum;
    logic [CNT_W-1:0]  w_hi_m1;
    logic [CNT_W-1:0]  w_meas_period;
    logic [DUTY_W-1:0] w_meas_duty;
    logic              w_hi_timeout;
    logic              w_lo_timeout;

    pwm_capture_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .s      (w_s),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_hi_inc = (r_hi_cnt == c_CNT_MAX) ? r_hi_cnt : r_hi_cnt + CNT_W'(1);
    assign w_lo_inc = (r_lo_cnt == c_CNT_MAX) ? r_lo_cnt : r_lo_cnt + CNT_W'(1);

    assign w_sum         = {1'b0, r_hi_cnt} + {1'b0, r_lo_cnt};
    assign w_meas_period = w_sum[CNT_W] ? c_CNT_MAX : w_sum[CNT_W-1:0];
    assign w_hi_m1       = r_hi_cnt - CNT_W'(1);
    assign w_meas_duty   = (w_hi_m1 > CNT_W'(c_DUTY_MAX)) ? c_DUTY_MAX : w_hi_m1[DUTY_W-1:0];

    assign w_hi_timeout = w_s  && (r_hi_cnt == c_PERIOD);
    assign w_lo_timeout = !w_s && (r_lo_cnt == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_hi_cnt   <= '0;
            r_lo_cnt   <= '0;
            r_duty     <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_stuck_hi <= 1'b0;
            r_stuck_lo <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hi_cnt   <= w_hi_nxt;
            r_lo_cnt   <= w_lo_nxt;
            r_duty     <= w_duty_nxt;
            r_period   <= w_period_nxt;
            r_valid    <= w_valid_nxt;
            r_err      <= w_err_nxt;
            r_stuck_hi <= w_stuck_hi_nxt;
            r_stuck_lo <= w_stuck_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise)            w_state_nxt = HIGH;
                else if (w_lo_timeout) w_state_nxt = STUCK_LO;
            end
            HIGH: begin
                if (w_fall)            w_state_nxt = LOW;
                else if (w_hi_timeout) w_state_nxt = STUCK_HI;
            end
            LOW: begin
                if (w_rise)            w_state_nxt = HIGH;
                else if (w_lo_timeout) w_state_nxt = STUCK_LO;
            end
            STUCK_HI: if (w_fall) w_state_nxt = LOW;
            STUCK_LO: if (w_rise) w_state_nxt = HIGH;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Timeouts are checked before the increment so a saturated window holds.
    always_comb begin
        w_hi_nxt       = r_hi_cnt;
        w_lo_nxt       = r_lo_cnt;
        w_duty_nxt     = r_duty;
        w_period_nxt   = r_period;
        w_valid_nxt    = 1'b0;
        w_err_nxt      = r_err;
        w_stuck_hi_nxt = r_stuck_hi;
        w_stuck_lo_nxt = r_stuck_lo;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_hi_nxt = CNT_W'(1);
                    w_lo_nxt = '0;
                end else if (w_lo_timeout) begin
                    w_stuck_lo_nxt = 1'b1;
                end else if (!w_s) begin
                    w_lo_nxt = w_lo_inc;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_lo_nxt = CNT_W'(1);
                end else if (w_hi_timeout) begin
                    w_stuck_hi_nxt = 1'b1;
                    w_duty_nxt     = c_DUTY_MAX;
                    w_period_nxt   = c_PERIOD;
                    w_err_nxt      = 1'b0;
                    w_valid_nxt    = 1'b1;
                end else begin
                    w_hi_nxt = w_hi_inc;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_period_nxt   = w_meas_period;
                    w_duty_nxt     = w_meas_duty;
                    w_err_nxt      = (w_sum != c_PERIOD_X);
                    w_valid_nxt    = 1'b1;
                    w_stuck_hi_nxt = 1'b0;
                    w_stuck_lo_nxt = 1'b0;
                    w_hi_nxt       = CNT_W'(1);
                    w_lo_nxt       = '0;
                end else if (w_lo_timeout) begin
                    w_stuck_lo_nxt = 1'b1;
                    w_duty_nxt     = '0;
                end else begin
                    w_lo_nxt = w_lo_inc;
                end
            end
            STUCK_HI: begin
                if (w_fall) begin
                    w_stuck_hi_nxt = 1'b0;
                    w_lo_nxt       = CNT_W'(1);
                end else begin
                    w_hi_nxt = w_hi_inc;
                end
            end
            STUCK_LO: begin
                if (w_rise) begin
                    w_stuck_lo_nxt = 1'b0;
                    w_hi_nxt       = CNT_W'(1);
                    w_lo_nxt       = '0;
                end
            end
            default: begin
                w_hi_nxt = '0;
                w_lo_nxt = '0;
            end
        endcase
    end

    assign duty_out   = r_duty;
    assign period_out = r_period;
    assign valid      = r_valid;
    assign period_err = r_err;
    assign stuck_high = r_stuck_hi;
    assign stuck_low  = r_stuck_lo;

endmodule

`default_nettype wire
